// File: rtl/clb_param.sv
// Configurable logic block: NUM_BLE LUT+FF elements fed by a full crossbar,
// configured through a serial shift chain that can daisy-chain across tiles.
module clb_param #(
  parameter int NUM_BLE    = 4,
  parameter int LUT_K      = 4,
  parameter int NUM_INPUTS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  config_en,
  input  logic                  config_in,
  output logic                  config_out,
  output logic                  config_done,
  input  logic [NUM_INPUTS-1:0] data_in,
  output logic [NUM_BLE-1:0]    data_out
);

  localparam int SRC      = NUM_INPUTS + NUM_BLE + 1;
  localparam int SEL_W    = $clog2(SRC);
  localparam int SRC_PAD  = 2 ** SEL_W;
  localparam int MASK_W   = 2 ** LUT_K;
  localparam int MASK_LSB = LUT_K * SEL_W;
  localparam int BLE_BITS = MASK_LSB + MASK_W + 2;
  localparam int CFG_BITS = NUM_BLE * BLE_BITS;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  logic [CFG_BITS-1:0] r_cfg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_en_q;
  logic                r_done;
  logic [NUM_BLE-1:0]  r_q;

  logic [SRC_PAD-1:0]  w_src;
  logic [NUM_BLE-1:0]  w_lut;
  logic [NUM_BLE-1:0]  w_bypass;
  logic [NUM_BLE-1:0]  w_init;

  // Source vector zero-padded to a power of two: out-of-range selects read 0
  // without an explicit comparison. Feedback comes only from registered q.
  assign w_src = SRC_PAD'({r_q, data_in, 1'b0});

  for (genvar b = 0; b < NUM_BLE; b++) begin : g_ble
    logic [BLE_BITS-1:0] w_slice;
    logic [LUT_K-1:0]    w_idx;
    logic [MASK_W-1:0]   w_mask;

    assign w_slice = r_cfg[b*BLE_BITS +: BLE_BITS];

    for (genvar k = 0; k < LUT_K; k++) begin : g_in
      assign w_idx[k] = w_src[w_slice[k*SEL_W +: SEL_W]];
    end

    assign w_mask      = w_slice[MASK_LSB +: MASK_W];
    assign w_lut[b]    = w_mask[w_idx];
    assign w_bypass[b] = w_slice[MASK_LSB + MASK_W];
    assign w_init[b]   = w_slice[MASK_LSB + MASK_W + 1];
  end

  assign config_out  = r_cfg[CFG_BITS-1];
  assign config_done = r_done;

  // Serial configuration shift register, MSB of the frame enters first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= '0;
    end else if (config_en) begin
      r_cfg <= {r_cfg[CFG_BITS-2:0], config_in};
    end
  end

  // Bit counter: restarts at 1 on a new burst, saturates at the frame length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_en_q <= config_en;
      if (config_en) begin
        if (!r_en_q) begin
          r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_W'(CFG_BITS)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Frame-complete flag; any config_en cycle drops it on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_cnt == CNT_W'(CFG_BITS)) && !config_en;
    end
  end

  // BLE flip-flops: preset to FF_INIT while configuring, run once live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (config_en) begin
      r_q <= w_init;
    end else if (r_done) begin
      r_q <= w_lut;
    end
  end

  // Output select: combinational LUT or registered q, gated by config_done.
  always_comb begin
    data_out = '0;
    if (r_done) begin
      data_out = (w_bypass & w_lut) | (~w_bypass & r_q);
    end
  end

endmodule

// File: tb/tb_clb_param.sv
// Testbench for clb_param: directed scenarios plus randomized frames, all
// compared against a bit-level behavioural model of the configured cluster.
module tb_clb_param;

  localparam int N        = 4;
  localparam int K        = 4;
  localparam int I        = 10;
  localparam int SRC      = I + N + 1;
  localparam int SEL_W    = $clog2(SRC);
  localparam int MASK_LSB = K * SEL_W;
  localparam int BLE_BITS = MASK_LSB + 2 ** K + 2;
  localparam int CFG_BITS = N * BLE_BITS;

  logic         clk;
  logic         rst_n;
  logic         config_en;
  logic         config_in;
  logic         config_out;
  logic         config_done;
  logic [I-1:0] data_in;
  logic [N-1:0] data_out;

  clb_param #(
    .NUM_BLE   (N),
    .LUT_K     (K),
    .NUM_INPUTS(I)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .config_done(config_done),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  bit m_cfg [CFG_BITS];
  int m_cnt;
  bit m_enq;
  bit m_done;
  bit m_q   [N];
  bit fr    [CFG_BITS];

  function automatic int field(input int lsb, input int w);
    int v = 0;
    for (int j = 0; j < w; j++) v += int'(m_cfg[lsb + j]) << j;
    return v;
  endfunction

  function automatic bit m_src(input int sel);
    if (sel == 0) return 1'b0;
    if (sel <= I) return data_in[sel - 1];
    if (sel <= I + N) return m_q[sel - I - 1];
    return 1'b0;
  endfunction

  function automatic bit m_lut(input int b);
    int base = b * BLE_BITS;
    int idx = 0;
    for (int k = 0; k < K; k++) idx += int'(m_src(field(base + k * SEL_W, SEL_W))) << k;
    return m_cfg[base + MASK_LSB + idx];
  endfunction

  function automatic bit m_byp(input int b);
    return m_cfg[b * BLE_BITS + MASK_LSB + 2 ** K];
  endfunction

  function automatic bit m_init(input int b);
    return m_cfg[b * BLE_BITS + MASK_LSB + 2 ** K + 1];
  endfunction

  function automatic logic [N-1:0] m_dout();
    logic [N-1:0] v = '0;
    for (int b = 0; b < N; b++)
      if (m_done) v[b] = m_byp(b) ? m_lut(b) : m_q[b];
    return v;
  endfunction

  task automatic model_reset();
    foreach (m_cfg[i]) m_cfg[i] = 1'b0;
    foreach (m_q[i]) m_q[i] = 1'b0;
    m_cnt = 0; m_enq = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    bit nq [N];
    for (int b = 0; b < N; b++) begin
      if (config_en) nq[b] = m_init(b);
      else if (m_done) nq[b] = m_lut(b);
      else nq[b] = m_q[b];
    end
    m_q = nq;
    m_done = (m_cnt == CFG_BITS) && !config_en;
    if (config_en) begin
      for (int i = CFG_BITS - 1; i > 0; i--) m_cfg[i] = m_cfg[i - 1];
      m_cfg[0] = config_in;
      if (!m_enq) m_cnt = 1;
      else if (m_cnt < CFG_BITS) m_cnt = m_cnt + 1;
    end
    m_enq = config_en;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check_all(input string tg);
    check_val({tg, ".done"}, 32'(config_done), 32'(m_done));
    check_val({tg, ".cout"}, 32'(config_out), 32'(m_cfg[CFG_BITS - 1]));
    check_val({tg, ".dout"}, 32'(data_out), 32'(m_dout()));
  endtask

  task automatic cyc(input bit en, input bit cin, input logic [I-1:0] din, input string tg);
    config_en = en; config_in = cin; data_in = din;
    #1;
    check_all(tg);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst.dout", 32'(data_out), 32'h0);
    check_val("rst.done", 32'(config_done), 32'h0);
    check_val("rst.cout", 32'(config_out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst2.dout", 32'(data_out), 32'h0);
    check_val("rst2.done", 32'(config_done), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic clear_frame();
    foreach (fr[i]) fr[i] = 1'b0;
  endtask

  task automatic set_ble(input int b, input int s0, input int s1, input int s2, input int s3,
                         input logic [15:0] mask, input bit byp, input bit init);
    int base = b * BLE_BITS;
    int s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < SEL_W; j++) fr[base + k * SEL_W + j] = s[k][j];
    for (int j = 0; j < 2 ** K; j++) fr[base + MASK_LSB + j] = mask[j];
    fr[base + MASK_LSB + 2 ** K] = byp;
    fr[base + MASK_LSB + 2 ** K + 1] = init;
  endtask

  task automatic load_frame(input logic [I-1:0] din, input string tg);
    for (int i = CFG_BITS - 1; i >= 0; i--) cyc(1'b1, fr[i], din, tg);
  endtask

  bit sq [$];

  initial begin
    rst_n = 1'b0; config_en = 1'b0; config_in = 1'b0; data_in = '0;
    model_reset();

    // 1: reset and idle without configuration
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, I'($urandom), "idle");
      check_val("idle.dout0", 32'(data_out), 32'h0);
    end

    // 2: AND of data_in[1:0] with bypass
    clear_frame();
    set_ble(0, 1, 2, 0, 0, 16'h0008, 1'b1, 1'b0);
    load_frame('0, "t2ld");
    cyc(1'b0, 1'b0, '0, "t2go");
    config_en = 1'b0; data_in = 10'b11; #1;
    check_val("t2.and11", 32'(data_out[0]), 32'h1);
    cyc(1'b0, 1'b0, 10'b11, "t2a");
    data_in = 10'b01; #1;
    check_val("t2.and01", 32'(data_out[0]), 32'h0);
    cyc(1'b0, 1'b0, 10'b01, "t2b");

    // 3: same function, registered output
    clear_frame();
    set_ble(0, 1, 2, 0, 0, 16'h0008, 1'b0, 1'b0);
    load_frame('0, "t3ld");
    cyc(1'b0, 1'b0, '0, "t3go");
    config_en = 1'b0; data_in = 10'b11; #1;
    check_val("t3.lat0", 32'(data_out[0]), 32'h0);
    cyc(1'b0, 1'b0, 10'b11, "t3a");
    check_val("t3.lat1", 32'(data_out[0]), 32'h1);

    // 4: self-feedback toggler on BLE1
    clear_frame();
    set_ble(1, 12, 0, 0, 0, 16'h5555, 1'b0, 1'b0);
    load_frame('0, "t4ld");
    cyc(1'b0, 1'b0, '0, "t4go");
    for (int i = 0; i < 4; i++) begin
      check_val("t4.toggle", 32'(data_out[1]), 32'(i % 2));
      cyc(1'b0, 1'b0, '0, "t4");
    end

    // 5: short burst leaves logic dead; full burst brings it up
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'($urandom), '0, "t5short");
    cyc(1'b0, 1'b0, '0, "t5i0");
    cyc(1'b0, 1'b0, '0, "t5i1");
    check_val("t5.short_done", 32'(config_done), 32'h0);
    check_val("t5.short_dout", 32'(data_out), 32'h0);
    foreach (fr[i]) fr[i] = 1'($urandom);
    load_frame('0, "t5ld");
    config_en = 1'b0; #1;
    check_val("t5.done_pre", 32'(config_done), 32'h0);
    cyc(1'b0, 1'b0, '0, "t5go");
    check_val("t5.done_post", 32'(config_done), 32'h1);

    // 6: over-shift pass-through, then reset during a reload
    sq.delete();
    for (int i = 0; i < CFG_BITS + 8; i++) sq.push_back(1'($urandom));
    for (int k = 1; k <= CFG_BITS + 8; k++) begin
      cyc(1'b1, sq[k - 1], '0, "t6sh");
      if (k >= CFG_BITS) check_val("t6.pass", 32'(config_out), 32'(sq[k - CFG_BITS]));
    end
    cyc(1'b0, 1'b0, '0, "t6go");
    check_val("t6.done", 32'(config_done), 32'h1);
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'($urandom), '0, "t6rl");
    do_reset();
    cyc(1'b0, 1'b0, '0, "t6post");

    // randomized frames and data, each ending with an interrupting burst
    for (int r = 0; r < 6; r++) begin
      foreach (fr[i]) fr[i] = 1'($urandom);
      load_frame(I'($urandom), "rld");
      for (int c = 0; c < 40; c++) cyc(1'b0, 1'b0, I'($urandom), "rrun");
      for (int c = 0; c < 3; c++) cyc(1'b1, 1'($urandom), I'($urandom), "rint");
      for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, I'($urandom), "rdead");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
